// File: rtl/vliw_pkg.sv
// Shared defaults for the VLIW register file and scoreboard.
// Holds the default geometry and the address-width derivation.
package vliw_pkg;

    localparam int NSLOTS_DEF = 2;
    localparam int NREGS_DEF  = 8;
    localparam int DATA_W_DEF = 32;

    // Address width for a register file of nregs entries.
    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/vliw_scoreboard.sv
// Pending-bit scoreboard for long-latency producers.
// Drives the lockstep decode stall from the pending state.
module vliw_scoreboard
    import vliw_pkg::*;
#(
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int NREGS  = NREGS_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSLOTS*AW-1:0] rd_addr_a,
    input  logic [NSLOTS*AW-1:0] rd_addr_b,
    input  logic [NSLOTS-1:0]    iss_valid,
    input  logic [NSLOTS*AW-1:0] iss_rd,
    input  logic [NSLOTS-1:0]    iss_long,
    input  logic [NSLOTS-1:0]    wb_en,
    input  logic [NSLOTS*AW-1:0] wb_addr,
    input  logic [NSLOTS-1:0]    wb_clr,
    output logic                 stall,
    output logic [NREGS-1:0]     pending
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr_now;
    logic [NREGS-1:0] blocking;
    logic [NREGS-1:0] set_vec;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Hazard detection, clear/set vectors and next pending state.
    always_comb begin
        clr_now = '0;
        set_vec = '0;
        stall   = 1'b0;
        for (int s = 0; s < NSLOTS; s++) begin
            if (wb_en[s] && wb_clr[s] && in_range(wb_addr[s*AW +: AW]))
                clr_now[wb_addr[s*AW +: AW]] = 1'b1;
        end
        blocking = pending_q & ~clr_now;
        for (int s = 0; s < NSLOTS; s++) begin
            if (iss_valid[s]) begin
                if (in_range(rd_addr_a[s*AW +: AW]) &&
                    blocking[rd_addr_a[s*AW +: AW]])
                    stall = 1'b1;
                if (in_range(rd_addr_b[s*AW +: AW]) &&
                    blocking[rd_addr_b[s*AW +: AW]])
                    stall = 1'b1;
                if (in_range(iss_rd[s*AW +: AW]) &&
                    blocking[iss_rd[s*AW +: AW]])
                    stall = 1'b1;
            end
        end
        // Two long producers to one register in the same bundle.
        for (int s = 0; s < NSLOTS; s++) begin
            for (int t = s + 1; t < NSLOTS; t++) begin
                if (iss_valid[s] && iss_valid[t] &&
                    iss_long[s] && iss_long[t] &&
                    iss_rd[s*AW +: AW] == iss_rd[t*AW +: AW])
                    stall = 1'b1;
            end
        end
        if (!stall) begin
            for (int s = 0; s < NSLOTS; s++) begin
                if (iss_valid[s] && iss_long[s] &&
                    in_range(iss_rd[s*AW +: AW]))
                    set_vec[iss_rd[s*AW +: AW]] = 1'b1;
            end
        end
        // A same-edge set beats a clear.
        pending_d = (pending_q & ~clr_now) | set_vec;
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/vliw_regfile_scoreboard.sv
// Multi-slot VLIW register file with write-first bypass.
// Pending-bit hazard tracking lives in vliw_scoreboard.
module vliw_regfile_scoreboard
    import vliw_pkg::*;
#(
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSLOTS*AW-1:0]     rd_addr_a,
    input  logic [NSLOTS*AW-1:0]     rd_addr_b,
    output logic [NSLOTS*DATA_W-1:0] rd_data_a,
    output logic [NSLOTS*DATA_W-1:0] rd_data_b,
    input  logic [NSLOTS-1:0]        iss_valid,
    input  logic [NSLOTS*AW-1:0]     iss_rd,
    input  logic [NSLOTS-1:0]        iss_long,
    input  logic [NSLOTS-1:0]        wb_en,
    input  logic [NSLOTS*AW-1:0]     wb_addr,
    input  logic [NSLOTS*DATA_W-1:0] wb_data,
    input  logic [NSLOTS-1:0]        wb_clr,
    output logic                     stall,
    output logic [NREGS-1:0]         pending
);

    logic [DATA_W-1:0]        regs_q [NREGS];
    logic [DATA_W-1:0]        regs_d [NREGS];
    logic [NSLOTS*AW-1:0]     raddr  [2];
    logic [NSLOTS*DATA_W-1:0] rdata  [2];

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Array update; ascending slot order lets the highest slot win.
    always_comb begin
        regs_d = regs_q;
        for (int s = 0; s < NSLOTS; s++) begin
            if (wb_en[s] && in_range(wb_addr[s*AW +: AW]))
                regs_d[wb_addr[s*AW +: AW]] = wb_data[s*DATA_W +: DATA_W];
        end
    end

    // Register array with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    assign raddr[0] = rd_addr_a;
    assign raddr[1] = rd_addr_b;

    // Write-first read ports; out-of-range addresses read as zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            for (int s = 0; s < NSLOTS; s++) begin
                if (in_range(raddr[p][s*AW +: AW])) begin
                    rdata[p][s*DATA_W +: DATA_W] = regs_q[raddr[p][s*AW +: AW]];
                    for (int w = 0; w < NSLOTS; w++) begin
                        if (wb_en[w] &&
                            wb_addr[w*AW +: AW] == raddr[p][s*AW +: AW])
                            rdata[p][s*DATA_W +: DATA_W] =
                                wb_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign rd_data_a = rdata[0];
    assign rd_data_b = rdata[1];

    vliw_scoreboard #(
        .NSLOTS (NSLOTS),
        .NREGS  (NREGS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_clr    (wb_clr),
        .stall     (stall),
        .pending   (pending)
    );

endmodule

// File: tb/tb_vliw_regfile_scoreboard.sv
// Directed plus randomized bench for vliw_regfile_scoreboard.
// Expected values come from a per-register reference model.
module tb_vliw_regfile_scoreboard;

    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  rd_addr_a, rd_addr_b, iss_rd, wb_addr;
    logic [63:0] rd_data_a, rd_data_b, wb_data;
    logic [1:0]  iss_valid, iss_long, wb_en, wb_clr;
    logic        stall;
    logic [7:0]  pending;

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0] m_regs [8];
    bit        m_pend [8];

    always #5 clk = ~clk;

    vliw_regfile_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_clr    (wb_clr),
        .stall     (stall),
        .pending   (pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int fld(input logic [5:0] v, input int s);
        return int'(v[s*AW +: AW]);
    endfunction

    // Value a reader sees: latest same-cycle writeback, else the array.
    function automatic logic [31:0] m_read(input int addr);
        logic [31:0] v;
        v = m_regs[addr];
        for (int s = 0; s < 2; s++)
            if (wb_en[s] && fld(wb_addr, s) == addr)
                v = wb_data[s*32 +: 32];
        return v;
    endfunction

    function automatic bit m_cleared(input int r);
        for (int s = 0; s < 2; s++)
            if (wb_en[s] && wb_clr[s] && fld(wb_addr, s) == r)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_blocking(input int r);
        return m_pend[r] && !m_cleared(r);
    endfunction

    function automatic bit m_stall();
        for (int s = 0; s < 2; s++)
            if (iss_valid[s] && (m_blocking(fld(rd_addr_a, s)) ||
                                 m_blocking(fld(rd_addr_b, s)) ||
                                 m_blocking(fld(iss_rd, s))))
                return 1'b1;
        return iss_valid == 2'b11 && iss_long == 2'b11 &&
               fld(iss_rd, 0) == fld(iss_rd, 1);
    endfunction

    function automatic logic [7:0] m_pvec();
        logic [7:0] v;
        for (int r = 0; r < 8; r++) v[r] = m_pend[r];
        return v;
    endfunction

    // Advance the model across one clock edge with current inputs.
    task automatic m_edge();
        bit st;
        st = m_stall();
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 1'b0;
            end
            return;
        end
        for (int s = 0; s < 2; s++)
            if (wb_en[s]) m_regs[fld(wb_addr, s)] = wb_data[s*32 +: 32];
        for (int s = 0; s < 2; s++)
            if (wb_en[s] && wb_clr[s]) m_pend[fld(wb_addr, s)] = 1'b0;
        if (!st)
            for (int s = 0; s < 2; s++)
                if (iss_valid[s] && iss_long[s]) m_pend[fld(iss_rd, s)] = 1'b1;
    endtask

    task automatic idle();
        rd_addr_a = '0; rd_addr_b = '0; iss_rd = '0; wb_addr = '0;
        wb_data = '0; iss_valid = '0; iss_long = '0; wb_en = '0;
        wb_clr = '0;
    endtask

    // Check combinational outputs, then take one edge.
    task automatic cycle(input string tag);
        logic [63:0] ea, eb;
        #1;
        for (int s = 0; s < 2; s++) begin
            ea[s*32 +: 32] = m_read(fld(rd_addr_a, s));
            eb[s*32 +: 32] = m_read(fld(rd_addr_b, s));
        end
        chk({tag, ".rd_a"}, rd_data_a, ea);
        chk({tag, ".rd_b"}, rd_data_b, eb);
        chk({tag, ".stall"}, {63'd0, stall}, {63'd0, m_stall()});
        chk({tag, ".pend"}, {56'd0, pending}, {56'd0, m_pvec()});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        m_edge();
        #1;
        reset = 1'b0;

        // Reset then read every register on both ports.
        for (int r = 0; r < 8; r++) begin
            rd_addr_a = {r[2:0], r[2:0]};
            rd_addr_b = {r[2:0], r[2:0]};
            #1;
            chk("rst.rd", rd_data_a, 64'd0);
            chk("rst.stall", {63'd0, stall}, 64'd0);
            cycle("rst");
        end
        chk("rst.pend", {56'd0, pending}, 64'd0);

        // Same-register write conflict with bypass.
        idle();
        wb_en = 2'b11;
        wb_addr = {3'd3, 3'd3};
        wb_data = {32'h22, 32'h11};
        rd_addr_a = {3'd0, 3'd3};
        #1;
        chk("byp.same", {32'd0, rd_data_a[31:0]}, 64'h22);
        cycle("byp");
        idle();
        rd_addr_a = {3'd0, 3'd3};
        #1;
        chk("byp.array", {32'd0, rd_data_a[31:0]}, 64'h22);
        cycle("byp2");

        // Load-use stall until the writeback clears it.
        idle();
        iss_valid = 2'b10; iss_long = 2'b10; iss_rd = {3'd5, 3'd0};
        cycle("ld.iss");
        chk("ld.pend", {56'd0, pending}, 64'h20);
        idle();
        iss_valid = 2'b01; rd_addr_a = {3'd0, 3'd5};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld.stall", {63'd0, stall}, 64'd1);
            cycle("ld.wait");
        end
        wb_en = 2'b01; wb_clr = 2'b01; wb_addr = {3'd0, 3'd5};
        wb_data = {32'd0, 32'hABCD};
        #1;
        chk("ld.go", {63'd0, stall}, 64'd0);
        chk("ld.data", {32'd0, rd_data_a[31:0]}, 64'hABCD);
        cycle("ld.wb");
        chk("ld.clr", {56'd0, pending}, 64'd0);

        // Set and clear of r2 on the same edge: set wins.
        idle();
        iss_valid = 2'b01; iss_long = 2'b01; iss_rd = {3'd0, 3'd2};
        cycle("sc.iss");
        idle();
        wb_en = 2'b01; wb_clr = 2'b01; wb_addr = {3'd0, 3'd2};
        iss_valid = 2'b10; iss_long = 2'b10; iss_rd = {3'd2, 3'd0};
        #1;
        chk("sc.stall", {63'd0, stall}, 64'd0);
        cycle("sc.both");
        chk("sc.pend", {56'd0, pending}, 64'h04);
        idle();
        wb_en = 2'b01; wb_clr = 2'b01; wb_addr = {3'd0, 3'd2};
        cycle("sc.clr");

        // Dual long to one register, then WAW on a pending register.
        idle();
        iss_valid = 2'b11; iss_long = 2'b11; iss_rd = {3'd6, 3'd6};
        #1;
        chk("waw.dual", {63'd0, stall}, 64'd1);
        cycle("waw.dual");
        chk("waw.pend", {56'd0, pending}, 64'd0);
        idle();
        iss_valid = 2'b01; iss_long = 2'b01; iss_rd = {3'd0, 3'd4};
        cycle("waw.ld");
        idle();
        iss_valid = 2'b01; iss_rd = {3'd0, 3'd4};
        #1;
        chk("waw.rd", {63'd0, stall}, 64'd1);
        cycle("waw.rd");

        // Reset while stalled drops the stall on the next cycle.
        chk("rms.pend", {56'd0, pending}, 64'h10);
        reset = 1'b1;
        cycle("rms.rst");
        reset = 1'b0;
        rd_addr_a = {3'd3, 3'd3};
        #1;
        chk("rms.stall", {63'd0, stall}, 64'd0);
        chk("rms.data", rd_data_a, 64'd0);
        cycle("rms");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            rd_addr_a = 6'($urandom);
            rd_addr_b = 6'($urandom);
            iss_rd    = 6'($urandom);
            wb_addr   = 6'($urandom);
            iss_valid = 2'($urandom);
            iss_long  = 2'($urandom);
            wb_en     = 2'($urandom);
            wb_clr    = 2'($urandom);
            wb_data   = {$urandom, $urandom};
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vliw_regfile_scoreboard.md
VLIW_REGFILE_SCOREBOARD -- requirements
Module: vliw_regfile_scoreboard

Interface
REQ-001 Parameters SHALL be as follows.
- NSLOTS, default 2, number of issue slots.
- NREGS, default 8, number of architectural registers.
- DATA_W, default 32, register width.
- AW = clog2(NREGS), derived.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 rd_addr_a, rd_addr_b  input  NSLOTS*AW  two source register addresses per slot (slot s at bits [s*AW +: AW]).
REQ-005 rd_data_a, rd_data_b  output  NSLOTS*DATA_W  read data per slot.
REQ-006 iss_valid  input  NSLOTS  slot holds a valid instruction in decode.
REQ-007 iss_rd  input  NSLOTS*AW  destination register per slot.
REQ-008 iss_long  input  NSLOTS  slot's producer is long-latency (load); it marks its destination pending.
REQ-009 wb_en  input  NSLOTS  writeback enable per slot.
REQ-010 wb_addr  input  NSLOTS*AW  writeback register per slot.
REQ-011 wb_data  input  NSLOTS*DATA_W  writeback data per slot.
REQ-012 wb_clr  input  NSLOTS  this writeback completes a long-latency producer and clears its pending bit.
REQ-013 stall  output  1  decode SHALL NOT advance this cycle; applies to all slots in lockstep.
REQ-014 pending  output  NREGS  scoreboard state, bit r = register r awaits a long-latency result.

Function
REQ-015 The register array SHALL be written at the clock edge for every slot with wb_en=1.
REQ-016 If multiple slots write the same register in one cycle, the highest slot index SHALL win.
REQ-017 Reads SHALL be combinational and write-first: a same-cycle wb_en to the read address returns wb_data.
- Highest matching slot index wins.
- Otherwise the read returns the stored value.
REQ-018 Read latency SHALL be 0 cycles; a write SHALL be visible through the array one cycle after it is applied and through the bypass in the same cycle.
REQ-019 A register r SHALL be "cleared now" when any slot has wb_en=1, wb_clr=1 and wb_addr=r.
REQ-020 A register r SHALL be "blocking" when pending[r]=1 and it is not cleared now.
REQ-021 stall SHALL be 1 when any slot with iss_valid=1 has rd_addr_a, rd_addr_b or iss_rd naming a blocking register; the iss_rd case covers WAW.
REQ-022 stall SHALL be 1 when two valid slots both have iss_long=1 and the same iss_rd.
REQ-023 stall SHALL be purely combinational from inputs and the pending state.
REQ-024 On an edge with stall=0, pending[iss_rd[s]] SHALL be set for each slot s with iss_valid=1 and iss_long=1.
REQ-025 On every edge, pending[r] SHALL be cleared for each register r that is cleared now.
REQ-026 If a set and a clear hit the same register on one edge, the set SHALL win.
REQ-027 When stall=1, no pending bit SHALL be set that cycle; clears SHALL still apply.
REQ-028 wb_clr with wb_en=0 SHALL be ignored.
REQ-029 A clear of a non-pending register SHALL be harmless.
REQ-030 Address values >= NREGS SHALL be ignored on write and read as 0.

Reset
REQ-031 While reset=1 at an edge, all registers and all pending bits SHALL become 0, overriding same-cycle writes and sets.
REQ-032 The first edge after reset is released SHALL behave as an ordinary cycle.
REQ-033 Combinational outputs SHALL reflect the cleared state from the cycle after the reset edge: rd_data = 0 (absent bypass), stall = 0, pending = 0.
REQ-034 Reset asserted mid-stall SHALL clear the scoreboard, so stall drops on the next cycle.

Structure
REQ-035 Shared package vliw_pkg SHALL hold the default NSLOTS, NREGS and DATA_W and the AW derivation.
REQ-036 The pending-bit logic (REQ-019..REQ-029, REQ-031) SHALL be a sub-module named vliw_scoreboard.
REQ-037 The array and bypass logic SHALL remain in the top module.
REQ-038 The block SHALL contain no latches and one clock domain.

Verification
REQ-039 The bench SHALL cover these directed scenarios with default parameters:
- Reset then read: reset 1 cycle; read r0..r7 on both ports -> all 0, stall=0, pending=0x00.
- Bypass and conflict: same cycle, slot0 writes r3=0x11, slot1 writes r3=0x22, slot0 reads r3 -> 0x22 same cycle; next cycle array r3=0x22.
- Load-use: slot1 issues long to r5 -> pending=0x20; next cycle slot0 reads r5 -> stall=1 for 3 cycles; wb r5=0xABCD with wb_clr in the 4th -> stall=0 that cycle, rd_data=0xABCD, pending=0x00 after the edge.
- Set/clear collision: pending[2]=1; same edge wb_clr r2 and new long issue to r2 (no other hazard) -> pending[2] remains 1.
- WAW and dual long: both slots issue long to r6 -> stall=1, pending unchanged; separately, long pending on r4 plus issue writing r4 -> stall=1.
- Reset mid-stall: pending=0x10 with stall=1; assert reset -> next cycle pending=0, stall=0, data 0.
